alu_op_sequencer: RTL and testbench

//  Sequences one ALU instruction through the relay-style logic/arithmetic unit.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/relay_delay_counter.sv | 24 ++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU op sequencer: function codes, FSM states, opcode prefix.
package alu_pkg;

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_INC = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_XOR = 3'b100,
    FN_NOT = 3'b101,
    FN_SHL = 3'b110,
    FN_CLR = 3'b111
  } alu_fn_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_RELEASE,
    ST_DONE
  } seq_state_t;

  localparam logic [3:0] ALU_PREFIX = 4'b1000;

  // Only the arithmetic functions produce a meaningful carry.
  function automatic logic fn_sets_carry(alu_fn_t fn);
    return (fn == FN_ADD) || (fn == FN_INC);
  endfunction

endpackage

// File: rtl/relay_delay_counter.sv
// Loadable down-counter with zero flag; times both the settle and release windows.
module relay_delay_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; decrement stops at zero (always reloaded before reuse).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU instruction: settle with enable held, load strobe + flag latch,
// release with enables low, then a done pulse.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic [2:0] alu_fn,
  output logic       alu_en,
  output logic       ld_a,
  output logic       ld_d,
  output logic       busy,
  output logic       done,
  output logic       bad_op,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_s
);

  localparam int MAXC = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LD = CW'(RELEASE_CYCLES - 1);

  seq_state_t    state, state_n;
  logic [3:0]    op_q;      // r + fff; prefix is known once accepted
  logic          accept;
  logic          flag_ld;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val;
  alu_fn_t       fn;
  logic          is_alu_op;

  assign fn        = alu_fn_t'(op_q[2:0]);
  assign is_alu_op = (instr[7:4] == ALU_PREFIX);
  assign busy      = (state != ST_IDLE);

  relay_delay_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state, counter control and decoded outputs
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    flag_ld  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    alu_fn   = 3'b000;
    alu_en   = 1'b0;
    ld_a     = 1'b0;
    ld_d     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && is_alu_op) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LD;
          state_n  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        alu_fn = fn;
        alu_en = 1'b1;
        if (cnt_zero) state_n = ST_LOAD;
        else          cnt_dec = 1'b1;
      end
      ST_LOAD: begin
        alu_fn   = fn;
        alu_en   = 1'b1;
        ld_a     = ~op_q[3];
        ld_d     = op_q[3];
        flag_ld  = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = RELEASE_LD;
        state_n  = ST_RELEASE;
      end
      ST_RELEASE: begin
        alu_fn = fn;
        if (cnt_zero) state_n = ST_DONE;
        else          cnt_dec = 1'b1;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered opcode copy so instr may change while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       op_q <= '0;
    else if (accept) op_q <= instr[3:0];
  end

  // One-cycle reject pulse for a non-ALU opcode presented in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bad_op <= 1'b0;
    else       bad_op <= (state == ST_IDLE) && start && !is_alu_op;
  end

  // Condition flags: only the LOAD cycle updates them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
    end else if (flag_ld) begin
      flag_c <= fn_sets_carry(fn) ? alu_carry : 1'b0;
      flag_z <= alu_zero;
      flag_s <= alu_sign;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed table plus randomized ops
// compared cycle by cycle against a timing/flag reference model.
module tb_alu_op_sequencer;

  localparam int S = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset, start, alu_carry, alu_zero, alu_sign;
  logic [7:0] instr;
  logic [2:0] alu_fn;
  logic       alu_en, ld_a, ld_d, busy, done, bad_op, flag_c, flag_z, flag_s;

  int checks = 0;
  int errors = 0;

  // Reference flag state
  logic mc = 1'b0, mz = 1'b0, ms = 1'b0;

  alu_op_sequencer #(.SETTLE_CYCLES(S), .RELEASE_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_fn(alu_fn), .alu_en(alu_en), .ld_a(ld_a), .ld_d(ld_d),
    .busy(busy), .done(done), .bad_op(bad_op),
    .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic       c, z, s;
    int         kind;      // 0 normal, 1 start spam while busy, 2 bad opcode
    logic       ec, ez, es;
  } vec_t;

  // Expected outputs k cycles after the accepting edge (k=0: idle).
  // Layout: {fn[2:0], en, ld_a, ld_d, busy, done, bad, c, z, s}
  function automatic logic [11:0] exp_vec(int k, logic [7:0] op, logic fc, logic fz, logic fs);
    logic [2:0] f;
    logic       en, la, ldd, bz, dn;
    f   = (k >= 1 && k <= S + R + 1) ? op[2:0] : 3'b000;
    en  = (k >= 1 && k <= S + 1);
    la  = (k == S + 1) && !op[3];
    ldd = (k == S + 1) && op[3];
    bz  = (k >= 1 && k <= S + R + 2);
    dn  = (k == S + R + 2);
    return {f, en, la, ldd, bz, dn, 1'b0, fc, fz, fs};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {alu_fn, alu_en, ld_a, ld_d, busy, done, bad_op, flag_c, flag_z, flag_s};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (fn,en,la,ld,busy,done,bad,c,z,s)", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // One ALU op, checked every cycle from accept through done and back to idle.
  task automatic run_op(input logic [7:0] op, input logic c, input logic z, input logic s,
                        input bit noisy);
    @(negedge clk);
    check("pre_idle", exp_vec(0, op, mc, mz, ms));
    start = 1'b1;
    instr = op;
    for (int k = 1; k <= S + R + 2; k++) begin
      @(negedge clk);
      if (k == S + 2) begin
        mc = (op[2:0] <= 3'd1) ? c : 1'b0;
        mz = z;
        ms = s;
      end
      check($sformatf("op%02h_k%0d", op, k), exp_vec(k, op, mc, mz, ms));
      instr = 8'($urandom);
      start = noisy && (k != S + R + 2);
      if (k == S + 1) begin
        alu_carry = c; alu_zero = z; alu_sign = s;
      end else begin
        alu_carry = 1'($urandom); alu_zero = 1'($urandom); alu_sign = 1'($urandom);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("post_idle", exp_vec(0, op, mc, mz, ms));
  endtask

  // Non-ALU opcode in IDLE: one-cycle bad_op, nothing else moves.
  task automatic run_bad(input logic [7:0] op);
    logic [11:0] e;
    @(negedge clk);
    start = 1'b1;
    instr = op;
    @(negedge clk);
    e = exp_vec(0, op, mc, mz, ms);
    e[3] = 1'b1;
    check("bad_pulse", e);
    start = 1'b0;
    @(negedge clk);
    check("bad_clear", exp_vec(0, op, mc, mz, ms));
  endtask

  vec_t tbl[6];

  initial begin
    reset = 1'b1; start = 1'b0; instr = 8'h00;
    alu_carry = 1'b0; alu_zero = 1'b0; alu_sign = 1'b0;

    tbl[0] = '{op: 8'h83, c: 1'b0, z: 1'b0, s: 1'b1, kind: 0, ec: 1'b0, ez: 1'b0, es: 1'b1};
    tbl[1] = '{op: 8'h88, c: 1'b1, z: 1'b1, s: 1'b0, kind: 0, ec: 1'b1, ez: 1'b1, es: 1'b0};
    tbl[2] = '{op: 8'h82, c: 1'b1, z: 1'b0, s: 1'b1, kind: 0, ec: 1'b0, ez: 1'b0, es: 1'b1};
    tbl[3] = '{op: 8'h40, c: 1'b1, z: 1'b1, s: 1'b0, kind: 2, ec: 1'b0, ez: 1'b0, es: 1'b1};
    tbl[4] = '{op: 8'h89, c: 1'b1, z: 1'b0, s: 1'b0, kind: 1, ec: 1'b1, ez: 1'b0, es: 1'b0};
    tbl[5] = '{op: 8'h87, c: 1'b1, z: 1'b1, s: 1'b1, kind: 1, ec: 1'b0, ez: 1'b1, es: 1'b1};

    #1;
    check("reset_state", 12'b0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].kind == 2) run_bad(tbl[i].op);
      else run_op(tbl[i].op, tbl[i].c, tbl[i].z, tbl[i].s, tbl[i].kind == 1);
      check_bit($sformatf("tbl%0d_flag_c", i), flag_c, tbl[i].ec);
      check_bit($sformatf("tbl%0d_flag_z", i), flag_z, tbl[i].ez);
      check_bit($sformatf("tbl%0d_flag_s", i), flag_s, tbl[i].es);
    end

    // Reset during SETTLE: everything drops at once, flags clear, no done
    @(negedge clk);
    start = 1'b1;
    instr = 8'h85;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_k1", exp_vec(1, 8'h85, mc, mz, ms));
    @(negedge clk);
    check("rst_pre_k2", exp_vec(2, 8'h85, mc, mz, ms));
    #2 reset = 1'b1;
    #1;
    check("rst_async_drop", 12'b0);
    mc = 1'b0; mz = 1'b0; ms = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < S + R + 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet%0d", i), 12'b0);
    end
    run_op(8'h88, 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      op = 8'($urandom);
      if ($urandom_range(0, 3) != 0) op[7:4] = 4'b1000;
      if (op[7:4] != 4'b1000) run_bad(op);
      else run_op(op, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
